// File: rtl/elink_2bit_frame_rx.sv
// Receiver for the 2-bit uplink e-link: finds SOP, collects a 76-bit word, checks EOP and hands the word over a one-entry valid/ready buffer.
// Optional CRC-8 byte between payload and EOP is enabled by defining ELINK_RX_CRC_EN.
module elink_2bit_frame_rx #(
  parameter logic [7:0] SOP       = 8'h3C,
  parameter logic [7:0] EOP       = 8'hDC,
  parameter int         PAYLOAD_W = 76,
  parameter int         N_BYTES   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           rx_elink2bit,
  output logic [PAYLOAD_W-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 locked,
  output logic                 err_frame,
  output logic                 err_ovf,
  output logic                 err_crc,
  output logic [15:0]          frame_cnt
);

  localparam int         SREG_W    = N_BYTES * 8;
  localparam logic [3:0] LAST_BYTE = 4'(N_BYTES - 1);

  typedef enum logic [1:0] {ST_HUNT, ST_PAYLOAD, ST_CRC, ST_EOP} state_t;

  state_t                 state_q;
  logic [5:0]             win_q;
  logic [7:0]             win_d;
  logic [SREG_W-1:0]      sreg_q;
  logic [1:0]             dibit_cnt_q;
  logic [3:0]             byte_cnt_q;
  logic [PAYLOAD_W-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   locked_q;
  logic                   err_frame_q;
  logic                   err_ovf_q;
  logic [15:0]            frame_cnt_q;

  // Only the three previous dibits are stored; the current dibit completes the byte window.
  assign win_d = {win_q, rx_elink2bit};

`ifdef ELINK_RX_CRC_EN
  logic [7:0] crc_q;
  logic       err_crc_q;

  // CRC-8 (poly 0x07) advanced by one dibit, earlier bit first.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [1:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 1; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      win_q       <= '0;
      sreg_q      <= '0;
      dibit_cnt_q <= '0;
      byte_cnt_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      locked_q    <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      frame_cnt_q <= '0;
`ifdef ELINK_RX_CRC_EN
      crc_q       <= '0;
      err_crc_q   <= 1'b0;
`endif
    end else begin
      win_q       <= win_d[5:0];
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
`ifdef ELINK_RX_CRC_EN
      err_crc_q   <= 1'b0;
`endif
      // A reload later in this block overrides the clear (accept + new word).
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        ST_HUNT: begin
          if (win_d == SOP) begin
            state_q     <= ST_PAYLOAD;
            locked_q    <= 1'b1;
            dibit_cnt_q <= '0;
            byte_cnt_q  <= '0;
`ifdef ELINK_RX_CRC_EN
            crc_q       <= '0;
`endif
          end
        end
        ST_PAYLOAD: begin
          sreg_q      <= {sreg_q[SREG_W-3:0], rx_elink2bit};
          dibit_cnt_q <= dibit_cnt_q + 2'd1;
`ifdef ELINK_RX_CRC_EN
          crc_q       <= crc_step(crc_q, rx_elink2bit);
`endif
          if (dibit_cnt_q == 2'd3) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == LAST_BYTE) begin
`ifdef ELINK_RX_CRC_EN
              state_q <= ST_CRC;
`else
              state_q <= ST_EOP;
`endif
            end
          end
        end
`ifdef ELINK_RX_CRC_EN
        ST_CRC: begin
          dibit_cnt_q <= dibit_cnt_q + 2'd1;
          if (dibit_cnt_q == 2'd3) begin
            if (win_d != crc_q) begin
              err_crc_q <= 1'b1;
              locked_q  <= 1'b0;
              state_q   <= ST_HUNT;
            end else begin
              state_q   <= ST_EOP;
            end
          end
        end
`endif
        ST_EOP: begin
          dibit_cnt_q <= dibit_cnt_q + 2'd1;
          if (dibit_cnt_q == 2'd3) begin
            locked_q <= 1'b0;
            state_q  <= ST_HUNT;
            if (win_d != EOP || sreg_q[SREG_W-1:PAYLOAD_W] != '0) begin
              err_frame_q <= 1'b1;
            end else if (rx_valid_q && !rx_ready) begin
              err_ovf_q <= 1'b1;
            end else begin
              rx_data_q  <= sreg_q[PAYLOAD_W-1:0];
              rx_valid_q <= 1'b1;
              if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign locked    = locked_q;
  assign err_frame = err_frame_q;
  assign err_ovf   = err_ovf_q;
  assign frame_cnt = frame_cnt_q;
`ifdef ELINK_RX_CRC_EN
  assign err_crc   = err_crc_q;
`else
  assign err_crc   = 1'b0;
`endif

endmodule

// File: tb/tb_elink_2bit_frame_rx.sv
// Bench for elink_2bit_frame_rx: vector table of single frames plus hand sequences for
// overflow, accept+reload, mid-frame reset and (with ELINK_RX_CRC_EN) CRC errors.
module tb_elink_2bit_frame_rx;

  localparam logic [7:0] SOP_B = 8'h3C;
  localparam logic [7:0] EOP_B = 8'hDC;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rx;
  logic [75:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        locked;
  logic        err_frame;
  logic        err_ovf;
  logic        err_crc;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  int ferr_seen = 0;
  int crc_seen = 0;
  int exp_cnt = 0;
  logic [75:0] sb_q[$];

  typedef struct {
    logic [79:0] payload;
    logic [7:0]  eop;
    logic [1:0]  kind;   // 0 delivered, 1 framing error
  } vec_t;
  vec_t vecs[5];

`ifdef ELINK_RX_CRC_EN
  logic [7:0] crc_xor_g = 8'h00;

  function automatic logic [7:0] crc8(input logic [79:0] p);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 79; i >= 0; i--) begin
      fb = c[7] ^ p[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction
`endif

  always #5 clk = ~clk;

  elink_2bit_frame_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx_elink2bit (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .locked       (locked),
    .err_frame    (err_frame),
    .err_ovf      (err_ovf),
    .err_crc      (err_crc),
    .frame_cnt    (frame_cnt)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: a word leaves the buffer whenever valid and ready are both seen.
  always @(negedge clk) begin
    logic [75:0] e;
    if (!rst) begin
      if (err_ovf)   ovf_seen++;
      if (err_frame) ferr_seen++;
      if (err_crc)   crc_seen++;
      if (rx_valid && rx_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got word %h expected none", rx_data);
        end else begin
          e = sb_q.pop_front();
          chk("sb_word", 80'(rx_data), 80'(e));
          $display("accepted word %h", rx_data);
        end
      end
    end
  end

  task automatic send_dibit(input logic [1:0] d);
    @(posedge clk);
    #1 rx = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 3; k >= 0; k--) send_dibit(b[2*k +: 2]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx = 2'b00;
    end
  endtask

  task automatic send_frame(input logic [79:0] p, input logic [7:0] eop, input logic ready_end);
    send_byte(SOP_B);
    send_dibit(p[79:78]);
    @(negedge clk);
    chk("locked_after_sop", 80'(locked), 80'(1));
    for (int k = 1; k < 40; k++) send_dibit(p[79-2*k -: 2]);
`ifdef ELINK_RX_CRC_EN
    send_byte(crc8(p) ^ crc_xor_g);
`endif
    send_dibit(eop[7:6]);
    send_dibit(eop[5:4]);
    send_dibit(eop[3:2]);
    @(posedge clk);
    #1 rx = eop[1:0];
    if (ready_end) rx_ready = 1'b1;
    $display("frame sent payload %h eop %h", p, eop);
  endtask

  initial begin
    int o0, f0, c0;

    vecs[0] = '{80'h0_1234_5678_9ABC_DEF0_123, EOP_B, 2'd0};
    vecs[1] = '{80'h0_FEDC_BA98_7654_3210_ABC, 8'hDD, 2'd1};
    vecs[2] = '{80'h0_0000_0000_0000_0000_001, EOP_B, 2'd0};
    vecs[3] = '{80'h1_2345_6789_ABCD_EF01_234, EOP_B, 2'd1};
    vecs[4] = '{80'h0_FFFF_FFFF_FFFF_FFFF_FFF, EOP_B, 2'd0};

    rst = 1'b1;
    rx = 2'b00;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 80'(rx_valid), 80'(0));
    chk("rst_locked", 80'(locked), 80'(0));
    chk("rst_data", 80'(rx_data), 80'(0));
    chk("rst_cnt", 80'(frame_cnt), 80'(0));
    chk("rst_errs", 80'({err_frame, err_ovf, err_crc}), 80'(0));
    idle(4);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].kind == 2'd0) begin
        sb_q.push_back(vecs[i].payload[75:0]);
        exp_cnt++;
      end
      send_frame(vecs[i].payload, vecs[i].eop, 1'b0);
      idle(1);
      @(negedge clk);
      chk($sformatf("vec%0d_err_frame", i), 80'(err_frame), 80'(vecs[i].kind == 2'd1));
      chk($sformatf("vec%0d_err_ovf", i), 80'(err_ovf), 80'(0));
      chk($sformatf("vec%0d_err_crc", i), 80'(err_crc), 80'(0));
      chk($sformatf("vec%0d_valid", i), 80'(rx_valid), 80'(vecs[i].kind == 2'd0));
      chk($sformatf("vec%0d_locked", i), 80'(locked), 80'(0));
      chk($sformatf("vec%0d_cnt", i), 80'(frame_cnt), 80'(exp_cnt));
      idle(1);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_end", i), 80'(err_frame), 80'(0));
      chk($sformatf("vec%0d_valid_clr", i), 80'(rx_valid), 80'(0));
      idle(2);
    end

    // Buffer full, consumer accepts in the very cycle a new good frame closes.
    @(posedge clk);
    #1 rx_ready = 1'b0;
    sb_q.push_back(76'h1111_2222_3333_4444_555);
    exp_cnt++;
    send_frame(80'h0_1111_2222_3333_4444_555, EOP_B, 1'b0);
    idle(3);
    o0 = ovf_seen;
    sb_q.push_back(76'h0123_4567_0123_4567_012);
    exp_cnt++;
    send_frame(80'h0_0123_4567_0123_4567_012, EOP_B, 1'b1);
    idle(1);
    @(negedge clk);
    chk("reload_valid", 80'(rx_valid), 80'(1));
    chk("reload_data", 80'(rx_data), 80'(76'h0123_4567_0123_4567_012));
    chk("reload_cnt", 80'(frame_cnt), 80'(exp_cnt));
    idle(2);
    @(negedge clk);
    chk("reload_no_ovf", 80'(ovf_seen - o0), 80'(0));
    chk("reload_valid_clr", 80'(rx_valid), 80'(0));

    // Three back-to-back frames with the consumer stalled.
    @(posedge clk);
    #1 rx_ready = 1'b0;
    o0 = ovf_seen;
    sb_q.push_back(76'h0F1E_2D3C_4B5A_6978_877);
    exp_cnt++;
    send_frame(80'h0_0F1E_2D3C_4B5A_6978_877, EOP_B, 1'b0);
    send_frame(80'h0_3C3C_3C3C_3C3C_3C3C_3C3, EOP_B, 1'b0);
    send_frame(80'h0_AAAA_BBBB_CCCC_DDDD_EEE, EOP_B, 1'b0);
    idle(2);
    @(negedge clk);
    chk("b2b_ovf_pulses", 80'(ovf_seen - o0), 80'(2));
    chk("b2b_valid_held", 80'(rx_valid), 80'(1));
    chk("b2b_data_held", 80'(rx_data), 80'(76'h0F1E_2D3C_4B5A_6978_877));
    chk("b2b_cnt", 80'(frame_cnt), 80'(exp_cnt));
    @(posedge clk);
    #1 rx_ready = 1'b1;
    idle(1);
    @(negedge clk);
    chk("b2b_valid_clr", 80'(rx_valid), 80'(0));

    // Reset part-way through a payload with a word waiting in the buffer.
    @(posedge clk);
    #1 rx_ready = 1'b0;
    send_frame(80'h0_5555_5555_5555_5555_555, EOP_B, 1'b0);
    idle(2);
    o0 = ovf_seen;
    f0 = ferr_seen;
    c0 = crc_seen;
    send_byte(SOP_B);
    for (int k = 0; k < 20; k++) send_dibit(2'($urandom_range(0, 3)));
    @(posedge clk);
    #1 rst = 1'b1;
    rx = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp_cnt = 0;
    chk("mrst_locked", 80'(locked), 80'(0));
    chk("mrst_valid", 80'(rx_valid), 80'(0));
    chk("mrst_cnt", 80'(frame_cnt), 80'(0));
    idle(50);
    @(negedge clk);
    chk("mrst_no_err", 80'((ovf_seen - o0) + (ferr_seen - f0) + (crc_seen - c0)), 80'(0));
    @(posedge clk);
    #1 rx_ready = 1'b1;
    sb_q.push_back(76'h7777_6666_5555_4444_333);
    exp_cnt++;
    send_frame(80'h0_7777_6666_5555_4444_333, EOP_B, 1'b0);
    idle(1);
    @(negedge clk);
    chk("mrst_next_valid", 80'(rx_valid), 80'(1));
    chk("mrst_next_cnt", 80'(frame_cnt), 80'(exp_cnt));
    idle(3);

`ifdef ELINK_RX_CRC_EN
    crc_xor_g = 8'h00;
    sb_q.push_back(76'h89AB_CDEF_0123_4567_89A);
    exp_cnt++;
    send_frame(80'h0_89AB_CDEF_0123_4567_89A, EOP_B, 1'b0);
    idle(1);
    @(negedge clk);
    chk("crc_good_valid", 80'(rx_valid), 80'(1));
    chk("crc_good_cnt", 80'(frame_cnt), 80'(exp_cnt));
    idle(3);
    c0 = crc_seen;
    crc_xor_g = 8'h01;
    send_frame(80'h0_0000_1111_2222_3333_444, EOP_B, 1'b0);
    crc_xor_g = 8'h00;
    idle(3);
    @(negedge clk);
    chk("crc_bad_pulse", 80'(crc_seen - c0), 80'(1));
    chk("crc_bad_valid", 80'(rx_valid), 80'(0));
    chk("crc_bad_cnt", 80'(frame_cnt), 80'(exp_cnt));
`endif

    idle(2);
    @(negedge clk);
    chk("sb_empty", 80'(sb_q.size()), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
